// File: rtl/idex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush and
// external stall handling.
//
// Optional build macro: IDEX_PERF_CNT_EN enables the bubble and flush
// performance counters. Without it, both counter ports read constant 0.
//
// Stall/hold semantics: o_idex_LoadUseStall is a combinational hold request
// to the upstream stages (PC and IF/ID keep their contents this cycle), while
// this stage inserts a bubble. i_idex_ExtStall freezes this stage entirely.
// i_idex_Flush kills whatever would enter EX and suppresses the hold request.
module idex_pipe (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_idex_Valid,
    input  logic [31:0] i_idex_PC,
    input  logic [31:0] i_idex_Imm,
    input  logic [31:0] i_idex_Rs1Data,
    input  logic [31:0] i_idex_Rs2Data,
    input  logic [4:0]  i_idex_Rs1,
    input  logic [4:0]  i_idex_Rs2,
    input  logic [4:0]  i_idex_Rd,
    input  logic        i_idex_Rs1Used,
    input  logic        i_idex_Rs2Used,
    input  logic [3:0]  i_idex_AluOp,
    input  logic        i_idex_RegWrEn,
    input  logic        i_idex_MemWrEn,
    input  logic        i_idex_MemRdEn,
    input  logic        i_idex_Flush,
    input  logic        i_idex_ExtStall,
    output logic        o_idex_Valid,
    output logic [31:0] o_idex_PC,
    output logic [31:0] o_idex_Imm,
    output logic [31:0] o_idex_Rs1Data,
    output logic [31:0] o_idex_Rs2Data,
    output logic [4:0]  o_idex_Rs1,
    output logic [4:0]  o_idex_Rs2,
    output logic [4:0]  o_idex_Rd,
    output logic        o_idex_Rs1Used,
    output logic        o_idex_Rs2Used,
    output logic [3:0]  o_idex_AluOp,
    output logic        o_idex_RegWrEn,
    output logic        o_idex_MemWrEn,
    output logic        o_idex_MemRdEn,
    output logic        o_idex_LoadUseStall,
    output logic [31:0] o_idex_BubbleCnt,
    output logic [31:0] o_idex_FlushCnt
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;
    logic bubble_ins;

    // A live load in EX whose destination is read by the live ID instruction.
    // x0 is never a real destination, so it can never cause a stall.
    always_comb begin
        ex_is_load          = o_idex_Valid & o_idex_MemRdEn & o_idex_RegWrEn
                              & (o_idex_Rd != 5'd0);
        rs1_hit             = i_idex_Rs1Used & (i_idex_Rs1 == o_idex_Rd);
        rs2_hit             = i_idex_Rs2Used & (i_idex_Rs2 == o_idex_Rd);
        o_idex_LoadUseStall = ex_is_load & i_idex_Valid & (rs1_hit | rs2_hit)
                              & ~i_idex_Flush;
        bubble_ins          = o_idex_LoadUseStall & ~i_idex_ExtStall;
    end

    // Stage register: reset > flush > external stall > bubble > normal load.
    // Flush and bubble only zero the fields that can cause side effects;
    // the datapath fields keep their old value since nobody consumes them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_idex_Valid   <= 1'b0;
            o_idex_PC      <= '0;
            o_idex_Imm     <= '0;
            o_idex_Rs1Data <= '0;
            o_idex_Rs2Data <= '0;
            o_idex_Rs1     <= '0;
            o_idex_Rs2     <= '0;
            o_idex_Rd      <= '0;
            o_idex_Rs1Used <= 1'b0;
            o_idex_Rs2Used <= 1'b0;
            o_idex_AluOp   <= '0;
            o_idex_RegWrEn <= 1'b0;
            o_idex_MemWrEn <= 1'b0;
            o_idex_MemRdEn <= 1'b0;
        end else if (i_idex_Flush || (!i_idex_ExtStall && o_idex_LoadUseStall)) begin
            o_idex_Valid   <= 1'b0;
            o_idex_Rd      <= '0;
            o_idex_RegWrEn <= 1'b0;
            o_idex_MemWrEn <= 1'b0;
            o_idex_MemRdEn <= 1'b0;
        end else if (!i_idex_ExtStall) begin
            // Control bits are gated by valid so an empty slot is always inert.
            o_idex_Valid   <= i_idex_Valid;
            o_idex_PC      <= i_idex_PC;
            o_idex_Imm     <= i_idex_Imm;
            o_idex_Rs1Data <= i_idex_Rs1Data;
            o_idex_Rs2Data <= i_idex_Rs2Data;
            o_idex_Rs1     <= i_idex_Rs1;
            o_idex_Rs2     <= i_idex_Rs2;
            o_idex_Rd      <= i_idex_Rd;
            o_idex_Rs1Used <= i_idex_Rs1Used;
            o_idex_Rs2Used <= i_idex_Rs2Used;
            o_idex_AluOp   <= i_idex_AluOp;
            o_idex_RegWrEn <= i_idex_RegWrEn & i_idex_Valid;
            o_idex_MemWrEn <= i_idex_MemWrEn & i_idex_Valid;
            o_idex_MemRdEn <= i_idex_MemRdEn & i_idex_Valid;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;

    // Count inserted bubbles and applied flushes; both wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (i_idex_Flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (bubble_ins) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign o_idex_BubbleCnt = bubble_cnt;
    assign o_idex_FlushCnt  = flush_cnt;
`else
    logic unused_bubble;
    assign unused_bubble    = bubble_ins;
    assign o_idex_BubbleCnt = '0;
    assign o_idex_FlushCnt  = '0;
`endif

endmodule

// File: tb/tb_idex_pipe.sv
// Directed testbench for idex_pipe. Honours IDEX_PERF_CNT_EN for the
// expected counter values.
module tb_idex_pipe;

`ifdef IDEX_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_idex_Valid;
    logic [31:0] i_idex_PC, i_idex_Imm, i_idex_Rs1Data, i_idex_Rs2Data;
    logic [4:0]  i_idex_Rs1, i_idex_Rs2, i_idex_Rd;
    logic        i_idex_Rs1Used, i_idex_Rs2Used;
    logic [3:0]  i_idex_AluOp;
    logic        i_idex_RegWrEn, i_idex_MemWrEn, i_idex_MemRdEn;
    logic        i_idex_Flush, i_idex_ExtStall;
    logic        o_idex_Valid;
    logic [31:0] o_idex_PC, o_idex_Imm, o_idex_Rs1Data, o_idex_Rs2Data;
    logic [4:0]  o_idex_Rs1, o_idex_Rs2, o_idex_Rd;
    logic        o_idex_Rs1Used, o_idex_Rs2Used;
    logic [3:0]  o_idex_AluOp;
    logic        o_idex_RegWrEn, o_idex_MemWrEn, o_idex_MemRdEn;
    logic        o_idex_LoadUseStall;
    logic [31:0] o_idex_BubbleCnt, o_idex_FlushCnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_bub;
    logic [31:0] exp_fl;
    logic [31:0] exp_q[$];

    idex_pipe dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_idex_Valid(i_idex_Valid),
        .i_idex_PC(i_idex_PC), .i_idex_Imm(i_idex_Imm),
        .i_idex_Rs1Data(i_idex_Rs1Data), .i_idex_Rs2Data(i_idex_Rs2Data),
        .i_idex_Rs1(i_idex_Rs1), .i_idex_Rs2(i_idex_Rs2), .i_idex_Rd(i_idex_Rd),
        .i_idex_Rs1Used(i_idex_Rs1Used), .i_idex_Rs2Used(i_idex_Rs2Used),
        .i_idex_AluOp(i_idex_AluOp), .i_idex_RegWrEn(i_idex_RegWrEn),
        .i_idex_MemWrEn(i_idex_MemWrEn), .i_idex_MemRdEn(i_idex_MemRdEn),
        .i_idex_Flush(i_idex_Flush), .i_idex_ExtStall(i_idex_ExtStall),
        .o_idex_Valid(o_idex_Valid), .o_idex_PC(o_idex_PC), .o_idex_Imm(o_idex_Imm),
        .o_idex_Rs1Data(o_idex_Rs1Data), .o_idex_Rs2Data(o_idex_Rs2Data),
        .o_idex_Rs1(o_idex_Rs1), .o_idex_Rs2(o_idex_Rs2), .o_idex_Rd(o_idex_Rd),
        .o_idex_Rs1Used(o_idex_Rs1Used), .o_idex_Rs2Used(o_idex_Rs2Used),
        .o_idex_AluOp(o_idex_AluOp), .o_idex_RegWrEn(o_idex_RegWrEn),
        .o_idex_MemWrEn(o_idex_MemWrEn), .o_idex_MemRdEn(o_idex_MemRdEn),
        .o_idex_LoadUseStall(o_idex_LoadUseStall),
        .o_idex_BubbleCnt(o_idex_BubbleCnt), .o_idex_FlushCnt(o_idex_FlushCnt)
    );

    // Clock generation.
    always #5 i_clk = ~i_clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one ID instruction; payload fields are derived from the PC.
    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw,
                          input logic mw, input logic mr);
        i_idex_Valid   = v;
        i_idex_PC      = pc;
        i_idex_Imm     = pc + 32'h10;
        i_idex_Rs1Data = pc ^ 32'hA5A5_0000;
        i_idex_Rs2Data = ~pc;
        i_idex_AluOp   = pc[5:2];
        i_idex_Rs1     = rs1;
        i_idex_Rs1Used = u1;
        i_idex_Rs2     = rs2;
        i_idex_Rs2Used = u2;
        i_idex_Rd      = rd;
        i_idex_RegWrEn = rw;
        i_idex_MemWrEn = mw;
        i_idex_MemRdEn = mr;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_idex_Flush = 1'b0;
        i_idex_ExtStall = 1'b0;
        step();
        i_rst = 1'b0;
        exp_bub = 32'd0;
        exp_fl = 32'd0;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_idex_Flush = 1'b0; i_idex_ExtStall = 1'b0;
        set_id(1, 32'h0000_0080, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1);
        step();
        // Valid ID inputs stay applied while reset is high.
        i_rst = 1'b1;
        step();
        checks++;
        if (o_idex_Valid !== 1'b0 || o_idex_PC !== 32'd0 || o_idex_Rd !== 5'd0 ||
            o_idex_Imm !== 32'd0 || o_idex_AluOp !== 4'd0 || o_idex_Rs1 !== 5'd0) begin
            errors++;
            $display("FAIL reset_fields: valid=%0b pc=%h rd=%0d imm=%h alu=%0d rs1=%0d, expected all 0",
                     o_idex_Valid, o_idex_PC, o_idex_Rd, o_idex_Imm, o_idex_AluOp, o_idex_Rs1);
        end
        checks++;
        if (o_idex_RegWrEn !== 1'b0 || o_idex_MemRdEn !== 1'b0 || o_idex_MemWrEn !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rw=%0b mr=%0b mw=%0b, expected 0",
                     o_idex_RegWrEn, o_idex_MemRdEn, o_idex_MemWrEn);
        end
        checks++;
        if (o_idex_BubbleCnt !== 32'd0 || o_idex_FlushCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: bub=%0d fl=%0d, expected 0 0", o_idex_BubbleCnt, o_idex_FlushCnt);
        end
        i_rst = 1'b0;
        exp_bub = 32'd0;
        exp_fl = 32'd0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 32'h40, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 1); // lw x5
        step();
        checks++;
        if (o_idex_Valid !== 1'b1 || o_idex_PC !== 32'h40 || o_idex_Rd !== 5'd5 || o_idex_MemRdEn !== 1'b1) begin
            errors++;
            $display("FAIL lu_load: valid=%0b pc=%h rd=%0d mr=%0b, expected 1 40 5 1",
                     o_idex_Valid, o_idex_PC, o_idex_Rd, o_idex_MemRdEn);
        end
        set_id(1, 32'h44, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0); // add x7,x5,x6
        #1;
        checks++;
        if (o_idex_LoadUseStall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall_on: got %0b expected 1", o_idex_LoadUseStall);
        end
        step();
        exp_bub = exp_bub + PERF;
        checks++;
        if (o_idex_Valid !== 1'b0 || o_idex_RegWrEn !== 1'b0 || o_idex_MemRdEn !== 1'b0 ||
            o_idex_Rd !== 5'd0 || o_idex_LoadUseStall !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble: valid=%0b rw=%0b mr=%0b rd=%0d stall=%0b, expected 0 0 0 0 0",
                     o_idex_Valid, o_idex_RegWrEn, o_idex_MemRdEn, o_idex_Rd, o_idex_LoadUseStall);
        end
        checks++;
        if (o_idex_BubbleCnt !== exp_bub) begin
            errors++;
            $display("FAIL lu_bubble_cnt: got %0d expected %0d", o_idex_BubbleCnt, exp_bub);
        end
        step();
        checks++;
        if (o_idex_Valid !== 1'b1 || o_idex_PC !== 32'h44 || o_idex_Rd !== 5'd7 || o_idex_LoadUseStall !== 1'b0) begin
            errors++;
            $display("FAIL lu_add_enters: valid=%0b pc=%h rd=%0d stall=%0b, expected 1 44 7 0",
                     o_idex_Valid, o_idex_PC, o_idex_Rd, o_idex_LoadUseStall);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_id(1, 32'h50, 5'd2, 1, 5'd0, 0, 5'd0, 1, 0, 1); // lw x0
        step();
        set_id(1, 32'h54, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0);
        #1;
        checks++;
        if (o_idex_LoadUseStall !== 1'b0) begin
            errors++;
            $display("FAIL nh_x0_stall: got %0b expected 0", o_idex_LoadUseStall);
        end
        step();
        checks++;
        if (o_idex_Valid !== 1'b1 || o_idex_PC !== 32'h54) begin
            errors++;
            $display("FAIL nh_x0_load: valid=%0b pc=%h expected 1 54", o_idex_Valid, o_idex_PC);
        end
        set_id(1, 32'h58, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 1); // lw x5
        step();
        set_id(1, 32'h5C, 5'd3, 1, 5'd5, 0, 5'd9, 1, 0, 0); // Rs2=5 but unused
        #1;
        checks++;
        if (o_idex_LoadUseStall !== 1'b0) begin
            errors++;
            $display("FAIL nh_rs2_unused_stall: got %0b expected 0", o_idex_LoadUseStall);
        end
        step();
        checks++;
        if (o_idex_Valid !== 1'b1 || o_idex_PC !== 32'h5C || o_idex_BubbleCnt !== 32'd0) begin
            errors++;
            $display("FAIL nh_rs2_unused_load: valid=%0b pc=%h bub=%0d expected 1 5c 0",
                     o_idex_Valid, o_idex_PC, o_idex_BubbleCnt);
        end
    endtask

    task automatic test_flush_vs_stall();
        do_reset();
        set_id(1, 32'h60, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 1); // lw x5
        step();
        set_id(1, 32'h64, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0);
        i_idex_Flush = 1'b1;
        #1;
        checks++;
        if (o_idex_LoadUseStall !== 1'b0) begin
            errors++;
            $display("FAIL fl_stall_forced: got %0b expected 0", o_idex_LoadUseStall);
        end
        step();
        i_idex_Flush = 1'b0;
        exp_fl = exp_fl + PERF;
        checks++;
        if (o_idex_Valid !== 1'b0 || o_idex_RegWrEn !== 1'b0 || o_idex_Rd !== 5'd0 || o_idex_MemRdEn !== 1'b0) begin
            errors++;
            $display("FAIL fl_kill: valid=%0b rw=%0b rd=%0d mr=%0b expected 0 0 0 0",
                     o_idex_Valid, o_idex_RegWrEn, o_idex_Rd, o_idex_MemRdEn);
        end
        checks++;
        if (o_idex_FlushCnt !== exp_fl || o_idex_BubbleCnt !== exp_bub) begin
            errors++;
            $display("FAIL fl_cnt: fl=%0d bub=%0d expected %0d %0d",
                     o_idex_FlushCnt, o_idex_BubbleCnt, exp_fl, exp_bub);
        end
    endtask

    task automatic test_ext_stall();
        do_reset();
        set_id(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
        step();
        i_idex_ExtStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + 32'(i * 4), 5'd4, 1, 5'd4, 1, 5'(10 + i), 1, 1, 0);
            step();
            checks++;
            if (o_idex_PC !== 32'h100 || o_idex_Rd !== 5'd3 || o_idex_Valid !== 1'b1 || o_idex_MemWrEn !== 1'b0) begin
                errors++;
                $display("FAIL es_hold[%0d]: pc=%h rd=%0d valid=%0b mw=%0b expected 100 3 1 0",
                         i, o_idex_PC, o_idex_Rd, o_idex_Valid, o_idex_MemWrEn);
            end
        end
        i_idex_ExtStall = 1'b0;
        set_id(1, 32'h300, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1); // lw x6
        step();
        checks++;
        if (o_idex_PC !== 32'h300 || o_idex_Rd !== 5'd6) begin
            errors++;
            $display("FAIL es_release: pc=%h rd=%0d expected 300 6", o_idex_PC, o_idex_Rd);
        end
        // Hazard present during an external stall: no bubble, nothing counted.
        set_id(1, 32'h304, 5'd6, 1, 5'd0, 0, 5'd7, 1, 0, 0);
        i_idex_ExtStall = 1'b1;
        step();
        checks++;
        if (o_idex_Valid !== 1'b1 || o_idex_PC !== 32'h300 || o_idex_BubbleCnt !== exp_bub ||
            o_idex_LoadUseStall !== 1'b1) begin
            errors++;
            $display("FAIL es_hazard_hold: valid=%0b pc=%h bub=%0d stall=%0b expected 1 300 %0d 1",
                     o_idex_Valid, o_idex_PC, o_idex_BubbleCnt, o_idex_LoadUseStall, exp_bub);
        end
        i_idex_ExtStall = 1'b0;
    endtask

    task automatic test_ctrl_gating();
        do_reset();
        set_id(0, 32'h400, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1);
        step();
        checks++;
        if (o_idex_Valid !== 1'b0 || o_idex_RegWrEn !== 1'b0 || o_idex_MemWrEn !== 1'b0 || o_idex_MemRdEn !== 1'b0) begin
            errors++;
            $display("FAIL gate_invalid: valid=%0b rw=%0b mw=%0b mr=%0b expected 0 0 0 0",
                     o_idex_Valid, o_idex_RegWrEn, o_idex_MemWrEn, o_idex_MemRdEn);
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        set_id(1, 32'h500, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 1);
        step();
        set_id(1, 32'h504, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0);
        i_idex_ExtStall = 1'b1;
        i_idex_Flush = 1'b1;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_idex_Flush = 1'b0;
        i_idex_ExtStall = 1'b0;
        checks++;
        if (o_idex_Valid !== 1'b0 || o_idex_PC !== 32'd0 || o_idex_FlushCnt !== 32'd0 || o_idex_LoadUseStall !== 1'b0) begin
            errors++;
            $display("FAIL rst_override: valid=%0b pc=%h fl=%0d stall=%0b expected 0 0 0 0",
                     o_idex_Valid, o_idex_PC, o_idex_FlushCnt, o_idex_LoadUseStall);
        end
        exp_bub = 32'd0;
        exp_fl = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pc = 32'h1000 + 32'(i * 4);
            set_id(1, pc, 5'(i + 1), 1, 5'(i + 2), 1, 5'(20 + i), 1, 0, 0);
            exp_q.push_back(pc);
            step();
            exp_pc = exp_q.pop_front();
            checks++;
            if (o_idex_PC !== exp_pc || o_idex_Imm !== exp_pc + 32'h10 ||
                o_idex_AluOp !== exp_pc[5:2] || o_idex_Rs2Data !== ~exp_pc || o_idex_Valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: pc=%h imm=%h alu=%0d valid=%0b expected pc=%h imm=%h alu=%0d valid=1",
                         i, o_idex_PC, o_idex_Imm, o_idex_AluOp, o_idex_Valid,
                         exp_pc, exp_pc + 32'h10, exp_pc[5:2]);
            end
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
`ifdef IDEX_PERF_CNT_EN
        force dut.flush_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.flush_cnt;
        exp_fl = 32'hFFFF_FFFF;
`endif
        i_idex_Flush = 1'b1;
        step();
        i_idex_Flush = 1'b0;
        exp_fl = exp_fl + PERF;
        checks++;
        if (o_idex_FlushCnt !== exp_fl || o_idex_BubbleCnt !== exp_bub) begin
            errors++;
            $display("FAIL cnt_wrap: fl=%h bub=%h expected %h %h",
                     o_idex_FlushCnt, o_idex_BubbleCnt, exp_fl, exp_bub);
        end
    endtask

    // Test sequence and final report.
    initial begin
        i_rst = 1'b1;
        i_idex_Flush = 1'b0;
        i_idex_ExtStall = 1'b0;
        exp_bub = 32'd0;
        exp_fl = 32'd0;
        set_id(0, 32'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        step();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_vs_stall();
        test_ext_stall();
        test_ctrl_gating();
        test_reset_override();
        test_back_to_back();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idex_pipe.md
IDEX_PIPE -- requirements
Module: idex_pipe

Interface
REQ-001 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-002 i_rst  input  1  reset, synchronous, active-high.
REQ-003 i_idex_Valid  input  1  ID slot holds a real instruction.
REQ-004 i_idex_PC / i_idex_Imm / i_idex_Rs1Data / i_idex_Rs2Data  input  32 each  ID payload.
REQ-005 i_idex_Rs1 / i_idex_Rs2 / i_idex_Rd  input  5 each  ID register indices.
REQ-006 i_idex_Rs1Used / i_idex_Rs2Used  input  1 each  ID instruction actually reads Rs1/Rs2.
REQ-007 i_idex_AluOp  input  4  ALU operation code.
REQ-008 i_idex_RegWrEn / i_idex_MemWrEn / i_idex_MemRdEn  input  1 each  ID control bits.
REQ-009 i_idex_Flush  input  1  branch/jump redirect from EX; kill the instruction entering EX.
REQ-010 i_idex_ExtStall  input  1  downstream memory stall; freeze stage.
REQ-011 o_idex_<field>  output  same widths as REQ-003..REQ-008 inputs  registered EX-side copy of each field; o_idex_Rs1/o_idex_Rs2 feed the forwarding unit's IDEX register inputs.
REQ-012 o_idex_LoadUseStall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-013 o_idex_BubbleCnt / o_idex_FlushCnt  output  32 each  performance counters (see Configuration).

Function
REQ-014 Update priority per edge SHALL be: i_rst > i_idex_Flush > i_idex_ExtStall > load-use bubble > normal load.
REQ-015 Normal load: all o_idex_* fields SHALL take the ID inputs on the edge; latency exactly 1 cycle.
REQ-016 Flush: o_idex_Valid, o_idex_RegWrEn, o_idex_MemWrEn, o_idex_MemRdEn SHALL become 0 and o_idex_Rd SHALL become 0; other fields don't-care.
REQ-017 ExtStall (no Flush): every registered field SHALL hold its value.
REQ-018 o_idex_LoadUseStall SHALL be 1 iff o_idex_Valid & o_idex_MemRdEn & o_idex_RegWrEn & (o_idex_Rd != 0) & i_idex_Valid & ((i_idex_Rs1Used & i_idex_Rs1 == o_idex_Rd) | (i_idex_Rs2Used & i_idex_Rs2 == o_idex_Rd)), and i_idex_Flush = 0.
REQ-019 Load-use bubble (LoadUseStall=1, no ExtStall): register SHALL load a bubble (same zeroing as REQ-016); ID inputs are re-presented next cycle by the held upstream stage.
REQ-020 A single load-use hazard SHALL produce exactly one stall cycle (the bubble clears the match condition).
REQ-021 Registered control outputs SHALL never be 1 while o_idex_Valid = 0.
REQ-022 Flush and LoadUseStall asserted together: Flush wins; LoadUseStall output forced 0.
REQ-023 Index x0 as load destination SHALL never trigger a stall.

Reset
REQ-024 On i_rst, all o_idex_* registered fields SHALL be 0 on the next edge, both counters SHALL be 0.
REQ-025 Reset asserted mid-stall or mid-flush SHALL override both; first post-reset cycle presents an empty (invalid) stage.

Configuration
REQ-026 Macro IDEX_PERF_CNT_EN: when defined, o_idex_BubbleCnt SHALL increment by 1 on each edge a load-use bubble is inserted (REQ-019) and o_idex_FlushCnt on each edge a flush is applied; both wrap from 0xFFFFFFFF to 0; counters hold during ExtStall without flush.
REQ-027 When IDEX_PERF_CNT_EN is undefined, both counter ports SHALL remain present and be tied to constant 0, with no counter registers.

Verification
REQ-028 Reset: drive valid ID inputs, i_rst=1 one cycle -> all outputs 0, counters 0.
REQ-029 Load-use: EX holds lw x5 (Valid, MemRdEn, RegWrEn, Rd=5); ID add reads Rs1=5, Rs1Used=1 -> LoadUseStall=1 for exactly one cycle, next o_idex_Valid=0, following cycle add enters with Valid=1, BubbleCnt=1.
REQ-030 Non-hazards: same lw but Rd=0, or ID Rs2=5 with Rs2Used=0 -> LoadUseStall=0, add loads next cycle.
REQ-031 Flush vs stall: hazard of REQ-029 plus i_idex_Flush=1 same cycle -> LoadUseStall=0, o_idex_Valid=0, FlushCnt=1, BubbleCnt unchanged.
REQ-032 ExtStall: stage holds PC=0x100 with ExtStall=1 for 3 cycles while ID changes -> o_idex_PC stays 0x100, then loads ID value one cycle after release.
REQ-033 Counter wrap (IDEX_PERF_CNT_EN defined, counter preloaded via force to 0xFFFFFFFF): one flush -> FlushCnt=0; macro undefined -> both counters read 0 throughout.
